// File: rtl/bch_gf16_pkg.sv
// Shared constants for the binary BCH(15,7) double-error-correcting code
// over GF(16), plus the decoder state encoding and a field-inverse helper.
package bch_gf16_pkg;

    localparam int N        = 15;
    localparam int K        = 7;
    localparam int PARITY_W = 8;

    // x^4 + x + 1
    localparam logic [4:0] PRIM_POLY = 5'h13;
    // g(x) = x^8 + x^7 + x^6 + x^4 + 1, leading x^8 term implied
    localparam logic [7:0] GEN_MASK  = 8'hD1;

    // Field elements in polynomial basis
    localparam logic [3:0] ALPHA      = 4'h2;  // alpha
    localparam logic [3:0] ALPHA3     = 4'h8;  // alpha^3
    localparam logic [3:0] ALPHA_INV  = 4'h9;  // alpha^-1 = alpha^14
    localparam logic [3:0] ALPHA_INV2 = 4'hD;  // alpha^-2 = alpha^13

    // Decoder FSM encoding
    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_SYND  = 3'd1;
    localparam state_t ST_SOLVE = 3'd2;
    localparam state_t ST_CHIEN = 3'd3;
    localparam state_t ST_OUT   = 3'd4;

    // Multiplicative inverse in GF(16); inv(0) is defined as 0
    function automatic logic [3:0] gf16_inv(input logic [3:0] a);
        logic [3:0] r;
        case (a)
            4'h1: r = 4'h1;
            4'h2: r = 4'h9;
            4'h3: r = 4'hE;
            4'h4: r = 4'hD;
            4'h5: r = 4'hB;
            4'h6: r = 4'h7;
            4'h7: r = 4'h6;
            4'h8: r = 4'hF;
            4'h9: r = 4'h2;
            4'hA: r = 4'hC;
            4'hB: r = 4'h5;
            4'hC: r = 4'hA;
            4'hD: r = 4'h4;
            4'hE: r = 4'h3;
            4'hF: r = 4'h8;
            default: r = 4'h0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/gf16_mul.sv
// Combinational GF(16) multiplier, shift-and-add with reduction by x^4+x+1.
module gf16_mul
    import bch_gf16_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [3:0] p
);

    logic [3:0] acc;
    logic [3:0] sh;

    // Accumulate a*x^i for every set bit of b, reducing a*x^i as it shifts
    always_comb begin
        acc = 4'h0;
        sh  = a;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) acc = acc ^ sh;
            sh = sh[3] ? ({sh[2:0], 1'b0} ^ PRIM_POLY[3:0]) : {sh[2:0], 1'b0};
        end
        p = acc;
    end

endmodule

// File: rtl/bch_15_7_decoder.sv
// BCH(15,7) decoder: serial syndrome computation, Peterson solve for the
// error locator, serial Chien search. Fixed 31-cycle latency, one word in
// flight at a time.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. in_ready is high only in IDLE. out_valid, once raised, holds
// together with stable result fields until the edge where out_ready is high.
module bch_15_7_decoder
    import bch_gf16_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   in_codeword,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [K-1:0]   out_message,
    output logic [1:0]     out_err_count,
    output logic           out_uncorrectable,
    output state_t         dbg_state
);

    state_t       state_q;
    logic [N-1:0] code_q;      // raw received word
    logic [N-1:0] corr_q;      // word with Chien flips applied so far
    logic [3:0]   s1_q;
    logic [3:0]   s3_q;
    logic [3:0]   t1_q;        // sigma1 * alpha^-k
    logic [3:0]   t2_q;        // sigma2 * alpha^-2k
    logic [3:0]   idx_q;       // bit index in SYND, step k in CHIEN
    logic [1:0]   deg_q;
    logic         deg_ok_q;
    logic [1:0]   root_cnt_q;

    logic [3:0]   s1_alpha, s3_alpha3, s1_sq, s1_cube, d_val, sig2_calc;
    logic [3:0]   t1_step, t2_step;

    gf16_mul u_mul_s1   (.a(s1_q),    .b(ALPHA),          .p(s1_alpha));
    gf16_mul u_mul_s3   (.a(s3_q),    .b(ALPHA3),         .p(s3_alpha3));
    gf16_mul u_mul_sq   (.a(s1_q),    .b(s1_q),           .p(s1_sq));
    gf16_mul u_mul_cube (.a(s1_sq),   .b(s1_q),           .p(s1_cube));
    gf16_mul u_mul_sig2 (.a(d_val),   .b(gf16_inv(s1_q)), .p(sig2_calc));
    gf16_mul u_mul_t1   (.a(t1_q),    .b(ALPHA_INV),      .p(t1_step));
    gf16_mul u_mul_t2   (.a(t2_q),    .b(ALPHA_INV2),     .p(t2_step));

    // D = S1^3 + S3; zero means a single error explains the syndromes
    assign d_val     = s1_cube ^ s3_q;
    assign in_ready  = (state_q == ST_IDLE);
    assign dbg_state = state_q;

    logic [3:0] sig1_new, sig2_new;
    logic [1:0] deg_new;
    logic       deg_ok_new;

    // Error-locator coefficients and expected degree from the syndromes
    always_comb begin
        sig1_new   = 4'h0;
        sig2_new   = 4'h0;
        deg_new    = 2'd0;
        deg_ok_new = 1'b1;
        if (s1_q == 4'h0) begin
            if (s3_q != 4'h0) deg_ok_new = 1'b0;
        end else if (d_val == 4'h0) begin
            sig1_new = s1_q;
            deg_new  = 2'd1;
        end else begin
            sig1_new = s1_q;
            sig2_new = sig2_calc;
            deg_new  = 2'd2;
        end
    end

    logic [3:0]   chien_eval;
    logic         root;
    logic [N-1:0] flip_mask;
    logic [N-1:0] corr_next;
    logic [1:0]   cnt_next;
    logic         unc_next;

    // One Chien step: sigma(alpha^-k) = 1 + t1 + t2; a root locates bit k
    always_comb begin
        chien_eval       = 4'h1 ^ t1_q ^ t2_q;
        root             = (chien_eval == 4'h0);
        flip_mask        = '0;
        flip_mask[idx_q] = root;
        corr_next        = corr_q ^ flip_mask;
        cnt_next         = root_cnt_q + {1'b0, root};
        unc_next         = !deg_ok_q || (cnt_next != deg_q);
    end

    // Control FSM and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q           <= ST_IDLE;
            code_q            <= '0;
            corr_q            <= '0;
            s1_q              <= 4'h0;
            s3_q              <= 4'h0;
            t1_q              <= 4'h0;
            t2_q              <= 4'h0;
            idx_q             <= 4'h0;
            deg_q             <= 2'd0;
            deg_ok_q          <= 1'b0;
            root_cnt_q        <= 2'd0;
            out_valid         <= 1'b0;
            out_message       <= '0;
            out_err_count     <= 2'd0;
            out_uncorrectable <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        code_q     <= in_codeword;
                        corr_q     <= in_codeword;
                        s1_q       <= 4'h0;
                        s3_q       <= 4'h0;
                        root_cnt_q <= 2'd0;
                        idx_q      <= 4'(N - 1);
                        state_q    <= ST_SYND;
                    end
                end
                ST_SYND: begin
                    // Horner evaluation of c(alpha) and c(alpha^3), MSB first
                    s1_q <= s1_alpha  ^ {3'b000, code_q[idx_q]};
                    s3_q <= s3_alpha3 ^ {3'b000, code_q[idx_q]};
                    if (idx_q == 4'h0) state_q <= ST_SOLVE;
                    else               idx_q   <= idx_q - 4'h1;
                end
                ST_SOLVE: begin
                    t1_q     <= sig1_new;
                    t2_q     <= sig2_new;
                    deg_q    <= deg_new;
                    deg_ok_q <= deg_ok_new;
                    idx_q    <= 4'h0;
                    state_q  <= ST_CHIEN;
                end
                ST_CHIEN: begin
                    corr_q     <= corr_next;
                    root_cnt_q <= cnt_next;
                    t1_q       <= t1_step;
                    t2_q       <= t2_step;
                    if (idx_q == 4'(N - 1)) begin
                        // Final step folds in the last root before deciding
                        out_valid         <= 1'b1;
                        out_uncorrectable <= unc_next;
                        out_message       <= unc_next ? code_q[N-1:PARITY_W]
                                                      : corr_next[N-1:PARITY_W];
                        out_err_count     <= unc_next ? 2'd0 : cnt_next;
                        state_q           <= ST_OUT;
                    end else begin
                        idx_q <= idx_q + 4'h1;
                    end
                end
                ST_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state_q   <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bch_15_7_decoder.sv
// Bench for bch_15_7_decoder: directed vectors, error-pattern sweeps and
// back-pressure/reset scenarios, checked through an expected-result queue.
module tb_bch_15_7_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [14:0] in_codeword;
    logic        out_valid;
    logic        out_ready;
    logic [6:0]  out_message;
    logic [1:0]  out_err_count;
    logic        out_uncorrectable;
    logic [2:0]  dbg_state;

    bch_15_7_decoder dut (
        .clk               (clk),
        .rst               (rst),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .in_codeword       (in_codeword),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_message       (out_message),
        .out_err_count     (out_err_count),
        .out_uncorrectable (out_uncorrectable),
        .dbg_state         (dbg_state)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard state: {uncorrectable, err_count, message}
    logic [9:0]  exp_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          accept_cyc = 0;
    logic        prev_valid = 1'b0;
    logic [14:0] pats[121];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic report();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    endtask

    // Systematic encoder model: parity = m(x)*x^8 mod g(x)
    function automatic logic [14:0] encode(input logic [6:0] m);
        logic [14:0] r;
        r = {m, 8'h00};
        for (int i = 14; i >= 8; i--)
            if (r[i]) r = r ^ (15'h01D1 << (i - 8));
        return {m, r[7:0]};
    endfunction

    // Bounded-distance reference: search every codeword for one within 2 bits
    function automatic logic [9:0] nearest(input logic [14:0] w);
        int d;
        for (int m = 0; m < 128; m++) begin
            d = $countones(encode(7'(m)) ^ w);
            if (d <= 2) return {1'b0, 2'(d), 7'(m)};
        end
        return {1'b1, 2'b00, w[14:8]};
    endfunction

    // Monitor: latency on out_valid rise, pop and compare on each handshake
    always @(negedge clk) begin
        logic [9:0] e;
        if (out_valid && !prev_valid)
            check("latency", 32'(cyc - accept_cyc), 32'd31);
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_result: got message %0h, expected no result", out_message);
            end else begin
                e = exp_q.pop_front();
                check("message",       32'(out_message),       32'(e[6:0]));
                check("err_count",     32'(out_err_count),     32'(e[8:7]));
                check("uncorrectable", 32'(out_uncorrectable), 32'(e[9]));
            end
        end
        prev_valid <= out_valid;
    end

    // Driver: wait for in_ready within a cycle budget
    task automatic wait_ready();
        int n = 0;
        while (!in_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL ready_timeout: in_ready=%0b, expected 1 within 200 cycles", in_ready);
            report();
        end
    endtask

    // Driver: present one word for one accepting cycle, push its expectation
    task automatic send(input logic [14:0] w, input logic [6:0] m,
                        input logic [1:0] c, input logic u);
        wait_ready();
        in_valid    = 1'b1;
        in_codeword = w;
        exp_q.push_back({u, c, m});
        @(posedge clk); #1;
        accept_cyc  = cyc;
        in_valid    = 1'b0;
        in_codeword = 15'($urandom);
    endtask

    // Time limit guard
    initial begin
        #1_000_000;
        n_tests++;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        report();
    end

    // Stimulus
    initial begin
        int          np;
        int          n;
        logic [6:0]  m;
        logic [14:0] w;
        logic [9:0]  e;

        np = 0;
        pats[np++] = 15'h0000;
        for (int i = 0; i < 15; i++) pats[np++] = 15'(1) << i;
        for (int i = 0; i < 15; i++)
            for (int j = i + 1; j < 15; j++)
                pats[np++] = (15'(1) << i) | (15'(1) << j);

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in_codeword = 15'h0000;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_in_ready",  32'(in_ready),          32'd1);
        check("rst_out_valid", 32'(out_valid),         32'd0);
        check("rst_message",   32'(out_message),       32'd0);
        check("rst_err_count", 32'(out_err_count),     32'd0);
        check("rst_unc",       32'(out_uncorrectable), 32'd0);
        check("rst_state",     32'(dbg_state),         32'd0);

        // Directed vectors
        send(15'h01D1, 7'h01, 2'd0, 1'b0);
        send(15'h41D1, 7'h01, 2'd1, 1'b0);
        send(15'h01D9, 7'h01, 2'd1, 1'b0);
        send(15'h00D0, 7'h01, 2'd2, 1'b0);
        send(15'h0000, 7'h00, 2'd0, 1'b0);

        // Back-pressure: hold result 10 cycles, in_valid pulses ignored
        wait_ready();
        out_ready = 1'b0;
        send(15'h41D1, 7'h01, 2'd1, 1'b0);
        n = 0;
        while (!out_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("bp_valid_seen", 32'(out_valid), 32'd1);
        for (int i = 0; i < 10; i++) begin
            check("bp_message",   32'(out_message),       32'h01);
            check("bp_err_count", 32'(out_err_count),     32'd1);
            check("bp_unc",       32'(out_uncorrectable), 32'd0);
            check("bp_valid",     32'(out_valid),         32'd1);
            check("bp_in_ready",  32'(in_ready),          32'd0);
            in_valid    = i[0];
            in_codeword = 15'h0000;
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_in_ready",  32'(in_ready),  32'd1);
        check("bp_release_out_valid", 32'(out_valid), 32'd0);

        // Reset in the middle of the Chien search drops the word
        send(15'h01D1, 7'h01, 2'd0, 1'b0);
        repeat (19) begin
            @(posedge clk); #1;
        end
        check("pre_rst_state_chien", 32'(dbg_state), 32'd3);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        void'(exp_q.pop_back());
        check("mid_rst_state",     32'(dbg_state), 32'd0);
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_in_ready",  32'(in_ready),  32'd1);
        send(15'h01D1, 7'h01, 2'd0, 1'b0);

        // Every message with one of the 0/1/2-bit error patterns
        for (int k = 0; k < 128; k++) begin
            m = 7'(k);
            e[1:0] = 2'($countones(pats[k % 121]));
            send(encode(m) ^ pats[k % 121], m, e[1:0], 1'b0);
        end

        // One message against every 0/1/2-bit error pattern
        for (int k = 0; k < 121; k++)
            send(encode(7'h5A) ^ pats[k], 7'h5A, 2'($countones(pats[k])), 1'b0);

        // Three-bit errors: beyond the code's reach, checked against the
        // bounded-distance reference (uncorrectable or miscorrected)
        for (int t = 0; t < 12; t++) begin
            m = 7'((t * 37 + 5) % 128);
            w = encode(m) ^ (15'(1) << (t % 15)) ^ (15'(1) << ((t + 4) % 15))
                          ^ (15'(1) << ((t + 9) % 15));
            e = nearest(w);
            send(w, e[6:0], e[8:7], e[9]);
        end

        wait_ready();
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        report();
    end

endmodule
